// File: rtl/int_to_float_seq.sv
// Iterative 32-bit integer to IEEE-754 single converter with strobe/ack handshakes.
// Define INT_TO_FLOAT_ROUND_EN for round-to-nearest-even; the default build truncates.
module int_to_float_seq #(
   parameter bit SIGNED_IN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] NORM  = 2'd1;
   localparam logic [1:0] ROUND = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]  state_reg;
   logic [31:0] mag_reg;
   logic [7:0]  e_reg;
   logic        s_reg;
   logic [31:0] z_reg;
   logic        z_stb_reg;

   logic        sign_in;
   logic [31:0] mag_in;
   logic [22:0] m_trunc;
   logic        round_inc;
   logic [30:0] em_rounded;

   // -2^31 negates to itself, which is the correct magnitude read as unsigned
   assign sign_in = SIGNED_IN ? input_a[31] : 1'b0;
   assign mag_in  = sign_in ? (~input_a + 32'd1) : input_a;

   assign m_trunc = mag_reg[30:8];

`ifdef INT_TO_FLOAT_ROUND_EN
   logic guard;
   logic sticky;
   assign guard     = mag_reg[7];
   assign sticky    = |mag_reg[6:0];
   assign round_inc = guard & (sticky | m_trunc[0]);
`else
   assign round_inc = 1'b0;
`endif

   // Exponent and mantissa rounded together so a mantissa carry bumps the exponent
   assign em_rounded = {e_reg, m_trunc} + {30'd0, round_inc};

   assign input_a_ack  = (state_reg == IDLE) & ~rst;
   assign output_z     = z_reg;
   assign output_z_stb = z_stb_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         mag_reg   <= 32'd0;
         e_reg     <= 8'd0;
         s_reg     <= 1'b0;
         z_reg     <= 32'd0;
         z_stb_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (input_a_stb) begin
                  s_reg   <= sign_in;
                  mag_reg <= mag_in;
                  e_reg   <= 8'd158;
                  if (mag_in == 32'd0) begin
                     z_reg     <= 32'd0;
                     z_stb_reg <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     state_reg <= NORM;
                  end
               end
            end
            NORM: begin
               if (mag_reg[31]) begin
                  state_reg <= ROUND;
               end else begin
                  mag_reg <= mag_reg << 1;
                  e_reg   <= e_reg - 8'd1;
               end
            end
            ROUND: begin
               z_reg     <= {s_reg, em_rounded};
               z_stb_reg <= 1'b1;
               state_reg <= DONE;
            end
            DONE: begin
               if (output_z_ack) begin
                  z_stb_reg <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int_to_float_seq.sv
// Bench for int_to_float_seq: a signed (index 0) and an unsigned (index 1) instance
// driven from a vector table with a scoreboard queue, plus handshake and reset sequences.
module tb_int_to_float_seq;

   logic             clk;
   logic             rst;
   logic [1:0][31:0] a;
   logic [1:0]       a_stb;
   logic [1:0]       a_ack;
   logic [1:0][31:0] z;
   logic [1:0]       z_stb;
   logic [1:0]       z_ack;

   int checks;
   int errors;
   logic [31:0] sbq[$];

   typedef struct {
      int          sel;
      logic [31:0] a;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

`ifdef INT_TO_FLOAT_ROUND_EN
   localparam logic [31:0] EXP_7FFF    = 32'h4F000000;
   localparam logic [31:0] EXP_ODD     = 32'h4B800002;
   localparam logic [31:0] EXP_UMAX    = 32'h4F800000;
   localparam logic [31:0] EXP_NEG7FFF = 32'hCF000000;
`else
   localparam logic [31:0] EXP_7FFF    = 32'h4EFFFFFF;
   localparam logic [31:0] EXP_ODD     = 32'h4B800001;
   localparam logic [31:0] EXP_UMAX    = 32'h4F7FFFFF;
   localparam logic [31:0] EXP_NEG7FFF = 32'hCEFFFFFF;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         int_to_float_seq #(.SIGNED_IN(gi == 0)) dut (
            .clk          (clk),
            .rst          (rst),
            .input_a      (a[gi]),
            .input_a_stb  (a_stb[gi]),
            .input_a_ack  (a_ack[gi]),
            .output_z     (z[gi]),
            .output_z_stb (z_stb[gi]),
            .output_z_ack (z_ack[gi])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", nm, act, req);
      end else begin
         $display("ok   %s value=%08h", nm, act);
      end
   endtask

   // Present a value and complete the accept edge; leaves time just after that edge.
   task automatic start_txn(input int idx, input logic [31:0] av, input logic [31:0] expv, input string nm);
      int n;
      @(negedge clk);
      a[idx]     = av;
      a_stb[idx] = 1'b1;
      sbq.push_back(expv);
      n = 0;
      while (!a_ack[idx] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk({nm, "_accept"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
      a_stb[idx] = 1'b0;
      a[idx]     = $urandom;
   endtask

   // Measure edges from accept to output strobe, compare against scoreboard, hold, then ack.
   task automatic finish_txn(input int idx, input int lat, input string nm, input int hold);
      int n;
      logic [31:0] e;
      n = 0;
      @(negedge clk);
      while (!z_stb[idx] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_latency"}, n, lat);
      if (sbq.size() == 0) begin
         chk({nm, "_scoreboard"}, 32'd0, 32'd1);
         e = 32'hxxxxxxxx;
      end else begin
         e = sbq.pop_front();
      end
      chk({nm, "_result"}, z[idx], e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_hold"}, {z_stb[idx], a_ack[idx], z[idx]}, {1'b1, 1'b0, e});
      end
      z_ack[idx] = 1'b1;
      @(posedge clk);
      #1;
      z_ack[idx] = 1'b0;
      @(negedge clk);
      chk({nm, "_released"}, {31'd0, z_stb[idx]}, 32'd0);
   endtask

   vec_t vecs[14];

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      a      = '0;
      a_stb  = '0;
      z_ack  = '0;

      vecs[0]  = '{0, 32'hFFFFFFFF, 32'hBF800000, 33, "s_minus1"};
      vecs[1]  = '{0, 32'h80000000, 32'hCF000000, 2,  "s_minint"};
      vecs[2]  = '{1, 32'h80000000, 32'h4F000000, 2,  "u_2pow31"};
      vecs[3]  = '{0, 32'h7FFFFFFF, EXP_7FFF,     3,  "s_maxint"};
      vecs[4]  = '{1, 32'h7FFFFFFF, EXP_7FFF,     3,  "u_maxint"};
      vecs[5]  = '{0, 32'h01000003, EXP_ODD,      9,  "tie_odd"};
      vecs[6]  = '{0, 32'h01000001, 32'h4B800000, 9,  "tie_even"};
      vecs[7]  = '{1, 32'h00000000, 32'h00000000, 0,  "u_zero"};
      vecs[8]  = '{0, 32'h00000000, 32'h00000000, 0,  "s_zero"};
      vecs[9]  = '{0, 32'h00001000, 32'h45800000, 21, "pow2_12"};
      vecs[10] = '{0, 32'h00FFFFFF, 32'h4B7FFFFF, 10, "exact24"};
      vecs[11] = '{1, 32'hFFFFFFFF, EXP_UMAX,     2,  "u_max"};
      vecs[12] = '{0, 32'h80000001, EXP_NEG7FFF,  3,  "s_negmax"};
      vecs[13] = '{0, 32'hFFFFFFFE, 32'hC0000000, 32, "s_minus2"};

      repeat (2) @(negedge clk);
      chk("reset_state", {30'd0, z_stb[0], a_ack[0]}, 32'd0);
      chk("reset_z", z[0], 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ack", {31'd0, a_ack[0]}, 32'd1);

      // One with a long consumer stall
      start_txn(0, 32'h00000001, 32'h3F800000, "one");
      finish_txn(0, 33, "one", 5);

      foreach (vecs[i]) begin
         start_txn(vecs[i].sel, vecs[i].a, vecs[i].exp, vecs[i].name);
         finish_txn(vecs[i].sel, vecs[i].lat, vecs[i].name, 1);
      end

      // No accept on the ack edge, even with a new input already presented
      start_txn(0, 32'h00000000, 32'h00000000, "zero_pre");
      @(negedge clk);
      chk("zero_pre_result", {z_stb[0], z[0][30:0]}, 32'h80000000);
      sbq.pop_front();
      a[0]     = 32'h00001000;
      a_stb[0] = 1'b1;
      z_ack[0] = 1'b1;
      sbq.push_back(32'h45800000);
      @(posedge clk);
      #1;
      z_ack[0] = 1'b0;
      chk("ack_edge_noaccept", {30'd0, a_ack[0], z_stb[0]}, 32'd2);
      @(posedge clk);
      #1;
      a_stb[0] = 1'b0;
      a[0]     = 32'hDEADBEEF;
      finish_txn(0, 21, "after_ack", 0);

      // Reset in the middle of normalisation discards the result
      start_txn(0, 32'h00000001, 32'h3F800000, "abort");
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid", {29'd0, z_stb[0], a_ack[0], |z[0]}, 32'd0);
      sbq.delete();
      @(negedge clk);
      chk("rst_held", {29'd0, z_stb[0], a_ack[0], |z[0]}, 32'd0);
      rst = 1'b0;
      start_txn(0, 32'h00000002, 32'h40000000, "post_rst");
      finish_txn(0, 32, "post_rst", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
